// File: rtl/ldw_pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: FSM states and PC-source selects.
package ldw_pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    MD_RUN  = 2'b01,
    MD_DONE = 2'b10
  } ldw_state_e;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_JREG   = 2'b11;

endpackage

// File: rtl/ldw_lat_cnt.sv
// Loadable down-counter with enable and zero flag; times MDU operations.
module ldw_lat_cnt #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (en) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign cnt  = cnt_reg;
  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/ldw_pipe_ctrl.sv
// Pipeline sequencer: merges load-use, memory-freeze and MDU stalls into
// per-stage write enables, bubble/flush controls and the MDU handshake.
module ldw_pipe_ctrl
  import ldw_pipe_ctrl_pkg::*;
#(
  parameter int MUL_LAT    = 4,
  parameter int DIV_LAT    = 32,
  parameter int CNT_W      = 6,
  parameter int DELAY_SLOT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_nostall,
  input  logic        id_md_op,
  input  logic        id_md_div,
  input  logic [1:0]  id_pcsource,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        md_start,
  output logic        md_div,
  output logic        md_busy,
  output logic        md_done,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_we,
  output logic        idex_bubble,
  output logic        exmem_we,
  output logic        memwb_we,
  output logic [31:0] stall_cnt
);

  // Counter runs LAT-2 .. 0 so the start cycle plus MD_RUN cycles equal LAT.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 2);

  ldw_state_e       state_reg;
  logic [31:0]      stall_cnt_reg;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             memfreeze;
  logic             start_go;
  logic             cnt_en;

  assign memfreeze = mem_req & ~mem_ready;
  assign start_go  = ~rst & ~memfreeze & (state_reg == IDLE) & id_nostall & id_md_op;
  assign cnt_en    = ~rst & ~memfreeze & (state_reg == MD_RUN) & ~cnt_zero;

  ldw_lat_cnt #(
    .W(CNT_W)
  ) u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (start_go),
    .load_val (id_md_div ? DIV_LOAD : MUL_LOAD),
    .en       (cnt_en),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else if (!memfreeze) begin
      case (state_reg)
        IDLE:    if (start_go) state_reg <= MD_RUN;
        MD_RUN:  if (cnt_zero) state_reg <= MD_DONE;
        MD_DONE: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    idex_we     = 1'b1;
    idex_bubble = 1'b0;
    exmem_we    = 1'b1;
    memwb_we    = 1'b1;
    if (rst) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_we     = 1'b0;
      idex_bubble = 1'b1;
      exmem_we    = 1'b0;
      memwb_we    = 1'b0;
    end else if (memfreeze) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_we  = 1'b0;
      exmem_we = 1'b0;
      memwb_we = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // Load-use hazard and MDU launch both hold the front end and bubble ID/EX.
          if (!id_nostall || id_md_op) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
          end
        end
        MD_RUN: begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_bubble = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ifid_flush = rst | ((DELAY_SLOT == 0) && (id_pcsource != PCSRC_SEQ) && pc_we);

  assign md_start = start_go;
  assign md_div   = start_go & id_md_div;
  assign md_busy  = ~rst & (state_reg == MD_RUN);
  // A freeze in MD_DONE defers the completion pulse to the cycle the pipe advances.
  assign md_done  = ~rst & ~memfreeze & (state_reg == MD_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (!pc_we && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_ldw_pipe_ctrl.sv
// Directed self-checking bench for ldw_pipe_ctrl (flush-enabled and delay-slot instances).
module tb_ldw_pipe_ctrl;
  import ldw_pipe_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_nostall;
  logic        id_md_op;
  logic        id_md_div;
  logic [1:0]  id_pcsource;
  logic        mem_req;
  logic        mem_ready;

  logic        md_start, md_div, md_busy, md_done;
  logic        pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_we;
  logic [31:0] stall_cnt;

  logic        d1_md_start, d1_md_div, d1_md_busy, d1_md_done;
  logic        d1_pc_we, d1_ifid_we, d1_ifid_flush, d1_idex_we, d1_idex_bubble;
  logic        d1_exmem_we, d1_memwb_we;
  logic [31:0] d1_stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ldw_pipe_ctrl #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(6), .DELAY_SLOT(0)) dut (
    .clk(clk), .rst(rst), .id_nostall(id_nostall), .id_md_op(id_md_op),
    .id_md_div(id_md_div), .id_pcsource(id_pcsource), .mem_req(mem_req),
    .mem_ready(mem_ready), .md_start(md_start), .md_div(md_div), .md_busy(md_busy),
    .md_done(md_done), .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_we(idex_we), .idex_bubble(idex_bubble), .exmem_we(exmem_we),
    .memwb_we(memwb_we), .stall_cnt(stall_cnt)
  );

  ldw_pipe_ctrl #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(6), .DELAY_SLOT(1)) dut_ds (
    .clk(clk), .rst(rst), .id_nostall(id_nostall), .id_md_op(id_md_op),
    .id_md_div(id_md_div), .id_pcsource(id_pcsource), .mem_req(mem_req),
    .mem_ready(mem_ready), .md_start(d1_md_start), .md_div(d1_md_div),
    .md_busy(d1_md_busy), .md_done(d1_md_done), .pc_we(d1_pc_we),
    .ifid_we(d1_ifid_we), .ifid_flush(d1_ifid_flush), .idex_we(d1_idex_we),
    .idex_bubble(d1_idex_bubble), .exmem_we(d1_exmem_we), .memwb_we(d1_memwb_we),
    .stall_cnt(d1_stall_cnt)
  );

  task automatic idle_inputs();
    rst = 1'b0; id_nostall = 1'b1; id_md_op = 1'b0; id_md_div = 1'b0;
    id_pcsource = 2'b00; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // Two reset cycles, leaving inputs idle at the start of the next cycle.
  task automatic do_reset();
    @(negedge clk); idle_inputs(); rst = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0; #1;
  endtask

  task automatic test_reset();
    @(negedge clk); idle_inputs(); rst = 1'b1; id_pcsource = 2'b10; #1;
    n_cmp++;
    if ({pc_we, ifid_we, idex_we, exmem_we, memwb_we} !== 5'b0 || idex_bubble !== 1'b1 || ifid_flush !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ctrl: we=%b bubble=%b flush=%b, required we=00000 bubble=1 flush=1",
               {pc_we, ifid_we, idex_we, exmem_we, memwb_we}, idex_bubble, ifid_flush);
    end
    @(negedge clk);
    @(negedge clk); idle_inputs(); #1;
    n_cmp++;
    if (stall_cnt !== 32'd0 || md_busy !== 1'b0 || md_done !== 1'b0 || pc_we !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_state: stall_cnt=%0d busy=%b done=%b pc_we=%b, required 0 0 0 1",
               stall_cnt, md_busy, md_done, pc_we);
    end
    $display("reset: stall_cnt=%0d pc_we=%b", stall_cnt, pc_we);
  endtask

  task automatic test_reset_mid_divide();
    int dones;
    do_reset();
    id_md_op = 1'b1; id_md_div = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clk);
    id_md_op = 1'b0; rst = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0; #1;
    n_cmp++;
    if (dut.state_reg !== IDLE || md_busy !== 1'b0 || stall_cnt !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_abort: state=%0d busy=%b stall_cnt=%0d, required 0 0 0",
               dut.state_reg, md_busy, stall_cnt);
    end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (md_done === 1'b1) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin
      n_bad++;
      $display("FAIL reset_no_done: md_done pulses=%0d, required 0", dones);
    end
    $display("reset mid-divide: md_done pulses=%0d", dones);
  endtask

  task automatic test_load_use();
    do_reset();
    id_nostall = 1'b0; #1;
    n_cmp++;
    if ({pc_we, ifid_we, idex_we, idex_bubble, exmem_we, memwb_we} !== 6'b001111) begin
      n_bad++;
      $display("FAIL load_use_ctrl: pc,ifid,idex,bub,exmem,memwb=%b, required 001111",
               {pc_we, ifid_we, idex_we, idex_bubble, exmem_we, memwb_we});
    end
    @(negedge clk); id_nostall = 1'b1; #1;
    n_cmp++;
    if (stall_cnt !== 32'd1 || pc_we !== 1'b1 || idex_bubble !== 1'b0) begin
      n_bad++;
      $display("FAIL load_use_after: stall_cnt=%0d pc_we=%b bubble=%b, required 1 1 0",
               stall_cnt, pc_we, idex_bubble);
    end
    $display("load-use: stall_cnt=%0d", stall_cnt);
  endtask

  task automatic test_multiply();
    int starts;
    do_reset();
    id_md_op = 1'b1; id_md_div = 1'b0; #1;
    n_cmp++;
    if (md_start !== 1'b1 || md_div !== 1'b0 || pc_we !== 1'b0 || idex_bubble !== 1'b1) begin
      n_bad++;
      $display("FAIL mul_t0: start=%b div=%b pc_we=%b bubble=%b, required 1 0 0 1",
               md_start, md_div, pc_we, idex_bubble);
    end
    starts = 0;
    for (int t = 1; t <= 3; t++) begin
      @(negedge clk); #1;
      if (md_start === 1'b1) starts++;
      n_cmp++;
      if (md_busy !== 1'b1 || pc_we !== 1'b0 || md_done !== 1'b0 || exmem_we !== 1'b1 || ifid_we !== 1'b0) begin
        n_bad++;
        $display("FAIL mul_run t%0d: busy=%b pc_we=%b done=%b exmem=%b ifid=%b, required 1 0 0 1 0",
                 t, md_busy, pc_we, md_done, exmem_we, ifid_we);
      end
    end
    @(negedge clk); #1;
    if (md_start === 1'b1) starts++;
    n_cmp++;
    if (md_done !== 1'b1 || md_busy !== 1'b0 || pc_we !== 1'b1 || ifid_we !== 1'b1 || idex_bubble !== 1'b0) begin
      n_bad++;
      $display("FAIL mul_t4: done=%b busy=%b pc_we=%b ifid=%b bubble=%b, required 1 0 1 1 0",
               md_done, md_busy, pc_we, ifid_we, idex_bubble);
    end
    @(negedge clk); id_md_op = 1'b0; #1;
    n_cmp++;
    if (md_done !== 1'b0 || starts !== 0 || stall_cnt !== 32'd4) begin
      n_bad++;
      $display("FAIL mul_after: done=%b extra_starts=%0d stall_cnt=%0d, required 0 0 4",
               md_done, starts, stall_cnt);
    end
    $display("multiply: stall_cnt=%0d extra_starts=%0d", stall_cnt, starts);
  endtask

  task automatic test_divide_freeze();
    int done_at;
    do_reset();
    id_md_op = 1'b1; id_md_div = 1'b1; #1;
    n_cmp++;
    if (md_start !== 1'b1 || md_div !== 1'b1) begin
      n_bad++;
      $display("FAIL div_start: start=%b div=%b, required 1 1", md_start, md_div);
    end
    done_at = -1;
    for (int t = 1; t <= 40 && done_at < 0; t++) begin
      @(negedge clk);
      mem_req = (t >= 2 && t <= 4); mem_ready = 1'b0;
      id_pcsource = (t >= 2 && t <= 4) ? 2'b10 : 2'b00;
      #1;
      if (t == 3) begin
        n_cmp++;
        if ({pc_we, ifid_we, idex_we, exmem_we, memwb_we} !== 5'b0 || idex_bubble !== 1'b0 ||
            ifid_flush !== 1'b0 || md_busy !== 1'b1) begin
          n_bad++;
          $display("FAIL div_freeze: we=%b bubble=%b flush=%b busy=%b, required 00000 0 0 1",
                   {pc_we, ifid_we, idex_we, exmem_we, memwb_we}, idex_bubble, ifid_flush, md_busy);
        end
      end
      if (md_done === 1'b1) done_at = t;
    end
    mem_req = 1'b0; id_pcsource = 2'b00;
    n_cmp++;
    if (done_at !== 35) begin
      n_bad++;
      $display("FAIL div_done_latency: md_done at cycle %0d, required 35", done_at);
    end
    @(negedge clk); id_md_op = 1'b0; #1;
    n_cmp++;
    if (stall_cnt !== 32'd35) begin
      n_bad++;
      $display("FAIL div_stall_cnt: stall_cnt=%0d, required 35", stall_cnt);
    end
    $display("divide+freeze: md_done at %0d stall_cnt=%0d", done_at, stall_cnt);
  endtask

  task automatic test_flush();
    do_reset();
    id_pcsource = 2'b10; #1;
    n_cmp++;
    if (ifid_flush !== 1'b1 || d1_ifid_flush !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_taken: flush=%b ds_flush=%b, required 1 0", ifid_flush, d1_ifid_flush);
    end
    @(negedge clk); id_pcsource = 2'b10; id_nostall = 1'b0; #1;
    n_cmp++;
    if (ifid_flush !== 1'b0 || d1_ifid_flush !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_stalled: flush=%b ds_flush=%b, required 0 0", ifid_flush, d1_ifid_flush);
    end
    @(negedge clk); id_pcsource = 2'b01; id_nostall = 1'b1; #1;
    n_cmp++;
    if (ifid_flush !== 1'b1 || d1_ifid_flush !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_branch: flush=%b ds_flush=%b, required 1 0", ifid_flush, d1_ifid_flush);
    end
    @(negedge clk); id_pcsource = 2'b00; #1;
    n_cmp++;
    if (ifid_flush !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_seq: flush=%b, required 0", ifid_flush);
    end
    $display("flush: checks done");
  endtask

  task automatic test_saturation();
    do_reset();
    force dut.stall_cnt_reg = 32'hFFFF_FFFD;
    #1 release dut.stall_cnt_reg;
    id_nostall = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if (stall_cnt !== 32'hFFFF_FFFE) begin
      n_bad++;
      $display("FAIL sat_step: stall_cnt=%h, required fffffffe", stall_cnt);
    end
    for (int i = 0; i < 3; i++) @(negedge clk);
    #1;
    n_cmp++;
    if (stall_cnt !== 32'hFFFF_FFFF) begin
      n_bad++;
      $display("FAIL sat_hold: stall_cnt=%h, required ffffffff", stall_cnt);
    end
    id_nostall = 1'b1;
    $display("saturation: stall_cnt=%h", stall_cnt);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_load_use();
    test_multiply();
    test_divide_freeze();
    test_reset_mid_divide();
    test_flush();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ldw_pipe_ctrl.md
Name: ldw_pipe_ctrl

Overview:
Pipeline sequencer for the 5-stage CPU. It merges three stall sources into one set of per-stage write enables, bubble/flush controls and a start/done handshake for the multi-cycle multiply/divide unit (MDU). The three sources are the ID-stage load-use hazard (nostall), a stalled data-memory access, and an MDU operation in flight. It sits beside the ID stage and drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
MUL_LAT, 4, cycles the MDU needs for a multiply (>=2)
DIV_LAT, 32, cycles the MDU needs for a divide (>=2)
CNT_W, 6, width of the latency counter; must hold DIV_LAT-1
DELAY_SLOT, 1, 1 = branch delay slot (no IF/ID flush on taken jump/branch); 0 = flush IF/ID on taken transfer

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
id_nostall  in  1  0 = load-use hazard detected in ID
id_md_op  in  1  instruction in ID is a mul/div
id_md_div  in  1  with id_md_op: 1 = divide, 0 = multiply
id_pcsource  in  2  PC select from ID; non-zero = taken branch/jump
mem_req  in  1  MEM stage is issuing a data-memory access
mem_ready  in  1  data memory completes the access this cycle
md_start  out  1  one-cycle pulse to launch the MDU
md_div  out  1  operation type, valid with md_start
md_busy  out  1  MDU operation in progress
md_done  out  1  one-cycle pulse; MDU result is valid
pc_we  out  1  PC register write enable
ifid_we  out  1  IF/ID write enable
ifid_flush  out  1  IF/ID load NOP
idex_we  out  1  ID/EX write enable
idex_bubble  out  1  ID/EX load NOP (control bits zeroed)
exmem_we  out  1  EX/MEM write enable
memwb_we  out  1  MEM/WB write enable
stall_cnt  out  32  count of cycles in which pc_we=0, saturating at all-ones

Behaviour:
- States: IDLE, MD_RUN, MD_DONE. Latency counter cnt[CNT_W-1:0].
- Reset (rst=1 at an edge): state goes to IDLE, cnt=0, md_start=0, md_done=0, md_busy=0, stall_cnt=0. While rst=1, all *_we=0, idex_bubble=1, ifid_flush=1.
- memfreeze = mem_req & ~mem_ready. This is the highest priority. It drives all five *_we to 0, bubble=0 and flush=0, and the FSM holds state and cnt; cnt does not decrement.
- IDLE with no freeze:
  - If ~id_nostall: pc_we=0, ifid_we=0, idex_we=1, idex_bubble=1; exmem_we=1, memwb_we=1.
  - Else if id_md_op: md_start=1 and md_div=id_md_div on the same cycle (combinational pulse). cnt loads (id_md_div ? DIV_LAT : MUL_LAT) - 2 and the FSM goes to MD_RUN. PC and IF/ID hold; ID/EX takes a bubble.
  - Else all *_we=1 with no bubble.
- MD_RUN: md_busy=1. PC and IF/ID hold, ID/EX takes a bubble, EX/MEM and MEM/WB advance. cnt decrements each cycle; at cnt==0 the FSM goes to MD_DONE.
- MD_DONE: md_done=1 and md_busy=0. All *_we=1, so the mul/div instruction leaves ID. The FSM then returns to IDLE. id_md_op is ignored in this state, so the same instruction never restarts the MDU.
- Total stall for an MDU op is exactly LAT cycles with pc_we=0, start cycle included. A freeze lengthens this by its own duration.
- Flush: if DELAY_SLOT=0 and id_pcsource!=0 and pc_we=1, then ifid_flush=1. Otherwise ifid_flush=0.
- A load-use stall takes effect only in IDLE. In MD_RUN the instruction in ID is already stalled.
- stall_cnt increments on every non-reset cycle with pc_we=0 and saturates.
- Reset during MD_RUN aborts the operation. No md_done is generated.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'b00, MD_RUN=2'b01, MD_DONE=2'b10) and the pcsource encodings.
- One sub-module, ldw_lat_cnt: a loadable down-counter with enable and a zero flag, instantiated for the MDU latency.
- Enable/bubble decoding stays combinational in the top module.

Test Plan:
- Reset: assert rst for 2 cycles mid-divide -> next cycle IDLE; md_busy=0, stall_cnt=0, no md_done.
- Load-use: id_nostall=0 for 1 cycle in IDLE -> pc_we=0, ifid_we=0, idex_bubble=1, exmem_we=1; stall_cnt +1.
- Multiply: id_md_op=1, id_md_div=0 -> md_start pulse at t0, md_busy t1..t3, md_done at t4, pc_we=0 for t0..t3 (4 cycles), no second md_start.
- Divide with memory freeze: divide starts, then mem_req=1, mem_ready=0 for 3 cycles during MD_RUN -> all *_we=0 in those cycles; md_done arrives 35 cycles after md_start.
- Flush: DELAY_SLOT=0, id_pcsource=2'b10, no stall -> ifid_flush=1. Same with id_nostall=0 -> ifid_flush=0. DELAY_SLOT=1 -> ifid_flush never asserted.
- Saturation: force stall_cnt near 32'hFFFFFFFF and hold a stall -> stall_cnt stays at 32'hFFFFFFFF.
